// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, constants and round helper functions.
//   aes_byte / aes_32 / aes_128  : byte, word and block types (block byte 0 is bits [127:120])
//   aes_bytes_t / aes_cols_t     : byte-indexed and column-indexed views of a block
//   aes_fsm_t                    : iterative core sequencing states
//   sbox, rcon, xtime, mix_column, mix_columns, shift_rows, sub_word : round primitives
package aes_pkg;

  typedef logic [7:0]        aes_byte;
  typedef logic [31:0]       aes_32;
  typedef logic [127:0]      aes_128;
  // Block byte i sits at index 15-i; column c sits at index 3-c.
  typedef logic [15:0][7:0]  aes_bytes_t;
  typedef logic [3:0][31:0]  aes_cols_t;

  localparam int AES_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DRAIN = 2'd2
  } aes_fsm_t;

  localparam aes_byte SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic aes_byte sbox(input aes_byte b);
    return SBOX_TABLE[b];
  endfunction

  // Round constant for the key schedule step producing round key r (r = 1..10).
  function automatic aes_byte rcon(input logic [3:0] round);
    aes_byte r;
    case (round)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic aes_byte xtime(input aes_byte b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_32 mix_column(input aes_32 c);
    aes_byte a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic aes_128 mix_columns(input aes_128 s);
    aes_cols_t v;
    v = s;
    for (int c = 0; c < 4; c++) begin
      v[2'(c)] = mix_column(v[2'(c)]);
    end
    return v;
  endfunction

  // Row r rotates left by r: output byte (r,c) comes from input byte (r,(c+r) mod 4).
  function automatic aes_128 shift_rows(input aes_128 s);
    aes_bytes_t ib;
    aes_bytes_t ob;
    ib = s;
    ob = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ob[4'(15 - (r + 4 * c))] = ib[4'(15 - (r + 4 * ((c + r) % 4)))];
      end
    end
    return ob;
  endfunction

  function automatic aes_32 sub_word(input aes_32 w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one AES-128 key expansion step (combinational).
//   round_key : current round key
//   rcon_byte : round constant for the key being produced
//   next_key  : following round key
// SubWord uses four private S-boxes so the schedule never competes with the state lanes.
module aes_key_step
  import aes_pkg::*;
(
  input  aes_128  round_key,
  input  aes_byte rcon_byte,
  output aes_128  next_key
);

  aes_32 w0_s, w1_s, w2_s, w3_s;
  aes_32 rot_s, sub_s, temp_s;
  aes_32 n0_s, n1_s, n2_s, n3_s;

  assign w0_s  = round_key[127:96];
  assign w1_s  = round_key[95:64];
  assign w2_s  = round_key[63:32];
  assign w3_s  = round_key[31:0];
  assign rot_s = {w3_s[23:0], w3_s[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sub
    aes_sbox u_sbox (
      .in_byte  (rot_s[8*b +: 8]),
      .out_byte (sub_s[8*b +: 8])
    );
  end

  assign temp_s   = sub_s ^ {rcon_byte, 24'h000000};
  assign n0_s     = w0_s ^ temp_s;
  assign n1_s     = w1_s ^ n0_s;
  assign n2_s     = w2_s ^ n1_s;
  assign n3_s     = w3_s ^ n2_s;
  assign next_key = {n0_s, n1_s, n2_s, n3_s};

endmodule

// File: rtl/aes_sbox.sv
// aes_sbox: single forward AES byte substitution (combinational).
//   in_byte  : byte to substitute
//   out_byte : S-box image of in_byte
module aes_sbox
  import aes_pkg::*;
(
  input  aes_byte in_byte,
  output aes_byte out_byte
);

  assign out_byte = sbox(in_byte);

endmodule

// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128 encryption core with cached master key.
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   in_valid_i    : request valid        in_ready_o  : core can accept a request
//   key_load_i    : 1 = take key_i as new master key, 0 = reuse cached key
//   key_i         : master key           plain_text_i: plaintext block
//   out_valid_o   : cipher_o holds a result   out_ready_i : consumer takes the result
//   cipher_o      : registered ciphertext     busy_o      : sequencer not idle
// SBOX_LANES byte S-boxes process the state a few columns per cycle, giving
// 16/SBOX_LANES cycles per round; the key schedule advances once per round.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int SBOX_LANES = 16,
  parameter int ROUNDS     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         key_load_i,
  input  logic [127:0] key_i,
  input  logic [127:0] plain_text_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] cipher_o,
  output logic         busy_o
);

  localparam int CPR     = 16 / SBOX_LANES;
  localparam int PHASE_W = (CPR > 1) ? $clog2(CPR) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CPR - 1);
  localparam logic [3:0]         ROUND_LAST = 4'(ROUNDS);

  if (ROUNDS != AES_ROUNDS) begin : g_bad_rounds
    $error("aes_iter_core: ROUNDS must be 10 for AES-128");
  end
  if (SBOX_LANES != 4 && SBOX_LANES != 8 && SBOX_LANES != 16) begin : g_bad_lanes
    $error("aes_iter_core: SBOX_LANES must be 4, 8 or 16");
  end

  aes_fsm_t             fsm_r, fsm_next_s;
  logic [3:0]           round_r;
  logic [PHASE_W-1:0]   phase_r;
  aes_128               master_key_r, round_key_r, state_r, sub_r, cipher_r;
  logic                 out_valid_r, in_ready_r, busy_r;

  logic                 accept_s, round_done_s, final_round_s, out_free_s;
  logic                 drain_go_s, load_out_s;
  aes_128               entry_key_s, next_key_s, shifted_s, mixed_s, round_out_s;
  aes_bytes_t           state_bytes_s, sub_full_s;
  logic [3:0]           lane_idx_s [SBOX_LANES];
  aes_byte              lane_out_s [SBOX_LANES];

  assign accept_s      = in_valid_i && in_ready_r;
  assign entry_key_s   = key_load_i ? key_i : master_key_r;
  assign round_done_s  = (fsm_r == ROUND) && (phase_r == PHASE_LAST);
  assign final_round_s = round_done_s && (round_r == ROUND_LAST);
  assign out_free_s    = !out_valid_r || out_ready_i;
  assign drain_go_s    = (fsm_r == DRAIN) && out_ready_i;
  assign load_out_s    = (final_round_s && out_free_s) || drain_go_s;
  assign state_bytes_s = state_r;

  // Lane j handles block byte phase*SBOX_LANES + j, i.e. whole columns in ascending order.
  for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
    assign lane_idx_s[j] = 4'((int'(phase_r) * SBOX_LANES) + j);
    aes_sbox u_sbox (
      .in_byte  (state_bytes_s[4'd15 - lane_idx_s[j]]),
      .out_byte (lane_out_s[j])
    );
  end

  aes_key_step u_key_step (
    .round_key (round_key_r),
    .rcon_byte (rcon(round_r)),
    .next_key  (next_key_s)
  );

  // Merge this cycle's lane outputs over the partially substituted buffer.
  always_comb begin
    sub_full_s = sub_r;
    for (int j = 0; j < SBOX_LANES; j++) begin
      sub_full_s[4'd15 - lane_idx_s[j]] = lane_out_s[j];
    end
  end

  // Finish the round: ShiftRows, MixColumns (not in the final round), AddRoundKey.
  always_comb begin
    shifted_s = shift_rows(sub_full_s);
    if (round_r == ROUND_LAST) begin
      mixed_s = shifted_s;
    end else begin
      mixed_s = mix_columns(shifted_s);
    end
    round_out_s = mixed_s ^ next_key_s;
  end

  // Sequencer next-state decision.
  always_comb begin
    fsm_next_s = fsm_r;
    case (fsm_r)
      IDLE: begin
        if (accept_s) begin
          fsm_next_s = ROUND;
        end else begin
          fsm_next_s = IDLE;
        end
      end
      ROUND: begin
        if (final_round_s) begin
          fsm_next_s = out_free_s ? IDLE : DRAIN;
        end else begin
          fsm_next_s = ROUND;
        end
      end
      DRAIN: begin
        if (out_ready_i) begin
          fsm_next_s = IDLE;
        end else begin
          fsm_next_s = DRAIN;
        end
      end
      default: fsm_next_s = IDLE;
    endcase
  end

  // Sequencer state plus registered ready/busy status derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_r      <= IDLE;
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      fsm_r      <= fsm_next_s;
      in_ready_r <= (fsm_next_s == IDLE);
      busy_r     <= (fsm_next_s != IDLE);
    end
  end

  // Datapath: master key cache, state, round key, partial substitution and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      master_key_r <= 128'h0;
      state_r      <= 128'h0;
      round_key_r  <= 128'h0;
      sub_r        <= 128'h0;
      round_r      <= 4'd0;
      phase_r      <= '0;
    end else if (accept_s) begin
      if (key_load_i) begin
        master_key_r <= key_i;
      end
      state_r     <= plain_text_i ^ entry_key_s;
      round_key_r <= entry_key_s;
      round_r     <= 4'd1;
      phase_r     <= '0;
    end else if (fsm_r == ROUND) begin
      sub_r <= sub_full_s;
      if (phase_r == PHASE_LAST) begin
        state_r     <= round_out_s;
        round_key_r <= next_key_s;
        round_r     <= round_r + 4'd1;
        phase_r     <= '0;
      end else begin
        phase_r <= phase_r + PHASE_W'(1);
      end
    end
  end

  // Output register: a fresh result loads straight from the final round or from DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cipher_r    <= 128'h0;
      out_valid_r <= 1'b0;
    end else if (load_out_s) begin
      cipher_r    <= (fsm_r == DRAIN) ? state_r : round_out_s;
      out_valid_r <= 1'b1;
    end else if (out_ready_i) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready_o  = in_ready_r;
  assign busy_o      = busy_r;
  assign out_valid_o = out_valid_r;
  assign cipher_o    = cipher_r;

endmodule
